rx: RTL and testbench
=====================

RX -- requirements
Module: rx

Interface
REQ-001 The block SHALL have the port rxclk, input, 1 bit: 125 MHz receive clock, the only clock, rising edge used.
REQ-002 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port rxbyte, input, 8 bits: one received byte per cycle from the DDR capture stage (low nibble = rising-edge rxd).
REQ-004 The block SHALL have the port rxdv, input, 1 bit: data valid (rising-edge rxctl).
REQ-005 The block SHALL have the port rxerr, input, 1 bit: receive error (rising rxctl XOR falling rxctl).
REQ-006 The block SHALL have the port dout, output, 8 bits: frame byte after SFD, FCS bytes included.
REQ-007 The block SHALL have the port dout_valid, output, 1 bit: dout is valid this cycle.
REQ-008 The block SHALL have the ports dout_sof and dout_eof, outputs, 1 bit each: first and last byte of the frame, qualified by dout_valid.
REQ-009 The block SHALL have the ports frame_ok and frame_bad, outputs, 1 bit each: one-cycle frame verdict pulses.
REQ-010 The block SHALL have the port frame_len, output, 11 bits: byte count after SFD incl. FCS, valid with the verdict.
REQ-011 The block SHALL have the ports cnt_ok and cnt_bad, outputs, 16 bits each: verdict counters.

Function
REQ-012 The FSM SHALL have the states IDLE, PREAMBLE, DATA and DROP, all updated on the rising edge of rxclk.
REQ-013 In IDLE: rxdv=1 with rxbyte=0x55 SHALL go to PREAMBLE; rxdv=1 with any other byte SHALL go to DROP; otherwise the FSM stays in IDLE.
REQ-014 In PREAMBLE: 0x55 SHALL stay in PREAMBLE; 0xD5 SHALL go to DATA (clearing CRC and length); any other byte SHALL go to DROP; rxdv=0 SHALL go to IDLE with no output and no verdict.
REQ-015 In DROP: the block SHALL stay in DROP until rxdv=0, then go to IDLE; it SHALL produce no output, no verdict and no counter change.
REQ-016 In DATA with rxdv=1: the byte SHALL update the CRC and length and enter a one-byte hold register; any previously held byte SHALL be emitted on dout with dout_valid=1.
REQ-017 Latency SHALL be 2 cycles from a byte on rxbyte to the same byte on dout.
REQ-018 dout_sof SHALL be 1 on the first emitted byte of a frame only.
REQ-019 On the first cycle of DATA with rxdv=0: the held byte SHALL be emitted with dout_eof=1, exactly one of frame_ok or frame_bad SHALL pulse in that same cycle, frame_len SHALL be driven, and the FSM SHALL go to IDLE.
REQ-020 A single-byte frame SHALL have dout_sof=dout_eof=1 on the same byte.
REQ-021 A frame ending directly after the SFD (length 0) SHALL pulse frame_bad with frame_len=0 and no dout_valid.
REQ-022 The CRC-32 SHALL use the reflected polynomial 0xEDB88320 with init 0xFFFFFFFF, be updated bytewise LSB-first over all bytes after the SFD including the FCS, and a correct frame SHALL leave a register value of 0xDEBB20E3 (no final XOR).
REQ-023 frame_bad SHALL be asserted if any of the following holds: CRC residue is wrong; rxerr=1 in any DATA cycle with rxdv=1; length <64; length >1518. Otherwise frame_ok SHALL be asserted.
REQ-024 The length counter SHALL saturate at 2047; bytes after 1518 SHALL still be emitted.
REQ-025 cnt_ok and cnt_bad SHALL increment by 1 per verdict and wrap 0xFFFF->0x0000.
REQ-026 rxdv going 1 in the cycle immediately after the DATA->IDLE transition SHALL be handled as a new frame from IDLE, with no byte lost.
REQ-027 rxerr outside DATA SHALL be ignored.

Reset
REQ-028 rst=1 SHALL asynchronously force the FSM to IDLE and clear the CRC, length, hold register, cnt_ok and cnt_bad.
REQ-029 During rst=1: dout=0x00, dout_valid=0, dout_sof=0, dout_eof=0, frame_ok=0, frame_bad=0, frame_len=0.
REQ-030 A reset mid-frame SHALL discard the frame with no verdict; if rxdv is still 1 after release, the rest of the frame SHALL go to DROP via REQ-013/014.

Verification
REQ-031 A 7x0x55, 0xD5, 60-byte payload, correct FCS frame SHALL give 64 dout bytes, sof on byte 1, eof on byte 64 with frame_ok, frame_len=64 and cnt_ok=1.
REQ-032 The same frame with one payload bit flipped SHALL give 64 bytes and frame_bad, with cnt_bad=1.
REQ-033 rxerr=1 on payload byte 10 of a CRC-correct 64-byte frame SHALL give frame_bad.
REQ-034 A 40-byte frame with correct FCS SHALL give frame_bad with frame_len=40.
REQ-035 rxdv dropping after 3 preamble bytes, and a frame whose preamble is followed by 0xAB, SHALL give no dout_valid, no verdict and unchanged counters.
REQ-036 rst pulsed at payload byte 20, then two back-to-back good frames separated by one rxdv=0 cycle, SHALL give: no verdict for the reset frame, the rest of that frame dropped, then two frame_ok pulses and cnt_ok=2.

Source files
------------

// File: rtl/rx.sv
// Receive framer: strips preamble/SFD, streams frame bytes with one byte of
// hold (so the last byte can be tagged eof), checks CRC-32 residue, length
// and error flags, and keeps ok/bad frame counters.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for rxdv; first byte must be a preamble 0x55
// PREAMBLE | inside preamble, waiting for the 0xD5 start-of-frame byte
// DATA     | frame body: emit held byte, accumulate CRC and length
// DROP     | malformed or interrupted frame, discard until rxdv falls
module rx (
    input  logic        rxclk,
    input  logic        rst,
    input  logic [7:0]  rxbyte,
    input  logic        rxdv,
    input  logic        rxerr,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic        dout_sof,
    output logic        dout_eof,
    output logic        frame_ok,
    output logic        frame_bad,
    output logic [10:0] frame_len,
    output logic [15:0] cnt_ok,
    output logic [15:0] cnt_bad
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0] LEN_MAX     = 11'd2047;
    localparam logic [10:0] LEN_MIN_OK  = 11'd64;
    localparam logic [10:0] LEN_MAX_OK  = 11'd1518;

    state_t      state;
    logic [31:0] crc;
    logic [10:0] len;
    logic [7:0]  hold;
    logic        err_seen;
    logic        sof_pend;
    logic        verdict_bad;

    // Reflected CRC-32, byte folded into the low bits then shifted out LSB-first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            if (r[0]) r = (r >> 1) ^ CRC_POLY;
            else      r = r >> 1;
        end
        return r;
    endfunction

    // Frame verdict from the state accumulated over the whole body.
    always_comb begin
        verdict_bad = (crc != CRC_RESIDUE) || err_seen ||
                      (len < LEN_MIN_OK) || (len > LEN_MAX_OK);
    end

    // Framing FSM with registered stream outputs, verdicts and counters.
    always_ff @(posedge rxclk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            crc        <= 32'h0;
            len        <= 11'd0;
            hold       <= 8'h00;
            err_seen   <= 1'b0;
            sof_pend   <= 1'b0;
            dout       <= 8'h00;
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
            dout_eof   <= 1'b0;
            frame_ok   <= 1'b0;
            frame_bad  <= 1'b0;
            frame_len  <= 11'd0;
            cnt_ok     <= 16'h0;
            cnt_bad    <= 16'h0;
        end else begin
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
            dout_eof   <= 1'b0;
            frame_ok   <= 1'b0;
            frame_bad  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rxdv) state <= (rxbyte == 8'h55) ? PREAMBLE : DROP;
                end
                PREAMBLE: begin
                    if (!rxdv) begin
                        state <= IDLE;
                    end else if (rxbyte == 8'hD5) begin
                        state    <= DATA;
                        crc      <= CRC_INIT;
                        len      <= 11'd0;
                        err_seen <= 1'b0;
                        sof_pend <= 1'b1;
                    end else if (rxbyte != 8'h55) begin
                        state <= DROP;
                    end
                end
                DATA: begin
                    if (rxdv) begin
                        // len != 0 means the hold register carries a real byte
                        if (len != 11'd0) begin
                            dout       <= hold;
                            dout_valid <= 1'b1;
                            dout_sof   <= sof_pend;
                            sof_pend   <= 1'b0;
                        end
                        hold <= rxbyte;
                        crc  <= crc_byte(crc, rxbyte);
                        if (len != LEN_MAX) len <= len + 11'd1;
                        if (rxerr) err_seen <= 1'b1;
                    end else begin
                        if (len != 11'd0) begin
                            dout       <= hold;
                            dout_valid <= 1'b1;
                            dout_sof   <= sof_pend;
                            dout_eof   <= 1'b1;
                            sof_pend   <= 1'b0;
                        end
                        if (verdict_bad) begin
                            frame_bad <= 1'b1;
                            cnt_bad   <= cnt_bad + 16'h1;
                        end else begin
                            frame_ok <= 1'b1;
                            cnt_ok   <= cnt_ok + 16'h1;
                        end
                        frame_len <= len;
                        state     <= IDLE;
                    end
                end
                DROP: begin
                    if (!rxdv) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx.sv
// Bench for the receive framer: table of whole-frame vectors plus hand-written
// cycle sequences for latency, short frames, aborts and reset mid-frame.
module tb_rx;

    logic        rxclk = 1'b0;
    logic        rst;
    logic [7:0]  rxbyte;
    logic        rxdv;
    logic        rxerr;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_sof;
    logic        dout_eof;
    logic        frame_ok;
    logic        frame_bad;
    logic [10:0] frame_len;
    logic [15:0] cnt_ok;
    logic [15:0] cnt_bad;

    rx dut (
        .rxclk(rxclk), .rst(rst), .rxbyte(rxbyte), .rxdv(rxdv), .rxerr(rxerr),
        .dout(dout), .dout_valid(dout_valid), .dout_sof(dout_sof), .dout_eof(dout_eof),
        .frame_ok(frame_ok), .frame_bad(frame_bad), .frame_len(frame_len),
        .cnt_ok(cnt_ok), .cnt_bad(cnt_bad)
    );

    always #4 rxclk = ~rxclk;

    int n_tests = 0;
    int n_fail  = 0;

    // monitor state, written only by the monitor process
    logic [7:0] mon_data [0:16383];
    int mon_n = 0, mon_ok = 0, mon_bad = 0, mon_sof = 0, mon_eof = 0;
    int mon_last_len = 0, mon_last_sof_idx = -1, mon_last_eof_idx = -1;
    int mon_eof_orphan = 0;

    always @(negedge rxclk) begin
        if (!rst) begin
            if (dout_valid) begin
                mon_data[mon_n] = dout;
                if (dout_sof) begin mon_sof++; mon_last_sof_idx = mon_n; end
                if (dout_eof) begin
                    mon_eof++; mon_last_eof_idx = mon_n;
                    if (!(frame_ok || frame_bad)) mon_eof_orphan++;
                end
                mon_n++;
            end
            if (frame_ok)  mon_ok++;
            if (frame_bad) mon_bad++;
            if (frame_ok || frame_bad) mon_last_len = int'(frame_len);
        end
    end

    // transmit buffer and expected counter values
    logic [7:0] tx_data [0:4095];
    int tx_n;
    int exp_cnt_ok = 0, exp_cnt_bad = 0;
    int s_n, s_ok, s_bad, s_sof, s_eof, s_orph;

    typedef struct {
        string name;
        int    npay;
        int    flip;
        int    err_idx;
        bit    err_pre;
        bit    exp_ok;
        int    exp_len;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic cyc(input logic [7:0] b, input logic dv, input logic er);
        rxbyte = b; rxdv = dv; rxerr = er;
        @(posedge rxclk);
        #1;
    endtask

    task automatic snap();
        s_n = mon_n; s_ok = mon_ok; s_bad = mon_bad;
        s_sof = mon_sof; s_eof = mon_eof; s_orph = mon_eof_orphan;
    endtask

    task automatic build_frame(input int npay, input int flip);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < npay; i++) begin
            tx_data[i] = 8'((i % 250) + 1);
            c = crc_ref(c, tx_data[i]);
        end
        c = ~c;
        tx_data[npay]   = c[7:0];
        tx_data[npay+1] = c[15:8];
        tx_data[npay+2] = c[23:16];
        tx_data[npay+3] = c[31:24];
        tx_n = npay + 4;
        if (flip >= 0) tx_data[flip/8][flip%8] = ~tx_data[flip/8][flip%8];
    endtask

    task automatic send_frame(input int err_idx, input bit err_pre, input int rst_at, input int gap);
        for (int i = 0; i < 7; i++) cyc(8'h55, 1'b1, err_pre);
        cyc(8'hD5, 1'b1, err_pre);
        for (int i = 0; i < tx_n; i++) begin
            cyc(tx_data[i], 1'b1, (i == err_idx));
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_mid_outputs", {dout, dout_valid, dout_sof, dout_eof, frame_ok, frame_bad, frame_len},
                    32'h0);
                chk("rst_mid_cnt", {cnt_ok, cnt_bad}, 32'h0);
                #1;
                rst = 1'b0;
                exp_cnt_ok = 0;
                exp_cnt_bad = 0;
                snap();
            end
        end
        for (int i = 0; i < gap; i++) cyc(8'h00, 1'b0, 1'b0);
    endtask

    task automatic check_frame(input string name, input int exp_n, input bit exp_ok, input int exp_len);
        int errs;
        @(negedge rxclk);
        #1;
        errs = 0;
        for (int i = 0; i < exp_n && (s_n + i) < mon_n; i++)
            if (mon_data[s_n + i] !== tx_data[i]) errs++;
        chk({name, "_nbytes"}, mon_n - s_n, exp_n);
        chk({name, "_data_errs"}, errs, 0);
        chk({name, "_sof_idx"}, mon_last_sof_idx, s_n);
        chk({name, "_eof_idx"}, mon_last_eof_idx, s_n + exp_n - 1);
        chk({name, "_sof_cnt"}, mon_sof - s_sof, 1);
        chk({name, "_eof_cnt"}, mon_eof - s_eof, 1);
        chk({name, "_eof_no_verdict"}, mon_eof_orphan - s_orph, 0);
        chk({name, "_ok"}, mon_ok - s_ok, exp_ok ? 1 : 0);
        chk({name, "_bad"}, mon_bad - s_bad, exp_ok ? 0 : 1);
        chk({name, "_len"}, mon_last_len, exp_len);
        chk({name, "_cnt_ok"}, cnt_ok, exp_cnt_ok);
        chk({name, "_cnt_bad"}, cnt_bad, exp_cnt_bad);
    endtask

    initial begin
        vecs[0] = '{"good64",     60,   -1,  -1, 1'b0, 1'b1, 64};
        vecs[1] = '{"bitflip",    60,  100,  -1, 1'b0, 1'b0, 64};
        vecs[2] = '{"rxerr_p10",  60,   -1,   9, 1'b0, 1'b0, 64};
        vecs[3] = '{"short40",    36,   -1,  -1, 1'b0, 1'b0, 40};
        vecs[4] = '{"err_in_pre", 60,   -1,  -1, 1'b1, 1'b1, 64};
        vecs[5] = '{"max1518",  1514,   -1,  -1, 1'b0, 1'b1, 1518};
        vecs[6] = '{"long1519", 1515,   -1,  -1, 1'b0, 1'b0, 1519};

        rst = 1'b1; rxbyte = 8'h55; rxdv = 1'b1; rxerr = 1'b1;
        #13;
        chk("reset_outputs", {dout, dout_valid, dout_sof, dout_eof, frame_ok, frame_bad, frame_len}, 32'h0);
        chk("reset_counters", {cnt_ok, cnt_bad}, 32'h0);
        rxdv = 1'b0; rxerr = 1'b0;
        #2 rst = 1'b0;
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);

        for (int v = 0; v < 7; v++) begin
            build_frame(vecs[v].npay, vecs[v].flip);
            if (vecs[v].exp_ok) exp_cnt_ok++; else exp_cnt_bad++;
            snap();
            send_frame(vecs[v].err_idx, vecs[v].err_pre, -1, 3);
            check_frame(vecs[v].name, vecs[v].npay + 4, vecs[v].exp_ok, vecs[v].exp_len);
        end

        // length counter saturates but every byte is still streamed out
        build_frame(2050, -1);
        exp_cnt_bad++;
        snap();
        send_frame(-1, 1'b0, -1, 3);
        check_frame("sat2047", 2054, 1'b0, 2047);

        // two-byte frame: exact latency and tagging cycle by cycle
        for (int i = 0; i < 7; i++) cyc(8'h55, 1'b1, 1'b0);
        cyc(8'hD5, 1'b1, 1'b0);
        cyc(8'h11, 1'b1, 1'b0);
        chk("lat_first_not_yet", dout_valid, 1'b0);
        cyc(8'h22, 1'b1, 1'b0);
        chk("lat_byte1", {dout, dout_valid, dout_sof, dout_eof}, {8'h11, 3'b110});
        cyc(8'h00, 1'b0, 1'b0);
        exp_cnt_bad++;
        chk("lat_byte2", {dout, dout_valid, dout_sof, dout_eof}, {8'h22, 3'b101});
        chk("two_verdict", {frame_ok, frame_bad, frame_len}, {2'b01, 11'd2});
        cyc(8'h00, 1'b0, 1'b0);
        chk("pulse_one_cycle", {dout_valid, frame_ok, frame_bad}, 3'b000);

        // single-byte frame carries sof and eof together
        for (int i = 0; i < 7; i++) cyc(8'h55, 1'b1, 1'b0);
        cyc(8'hD5, 1'b1, 1'b0);
        cyc(8'hA7, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        exp_cnt_bad++;
        chk("single_byte", {dout, dout_valid, dout_sof, dout_eof}, {8'hA7, 3'b111});
        chk("single_verdict", {frame_ok, frame_bad, frame_len}, {2'b01, 11'd1});

        // frame ends right after SFD
        for (int i = 0; i < 7; i++) cyc(8'h55, 1'b1, 1'b0);
        cyc(8'hD5, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        exp_cnt_bad++;
        chk("zero_len", {dout_valid, frame_ok, frame_bad, frame_len}, {3'b001, 11'd0});
        cyc(8'h00, 1'b0, 1'b0);
        chk("zero_len_cnt", {cnt_ok, cnt_bad}, {exp_cnt_ok[15:0], exp_cnt_bad[15:0]});

        // preamble abort and bad SFD produce nothing
        @(negedge rxclk); #1;
        snap();
        for (int i = 0; i < 3; i++) cyc(8'h55, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(8'h55, 1'b1, 1'b0);
        cyc(8'hAB, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cyc(8'(i + 3), 1'b1, 1'b1);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        @(negedge rxclk); #1;
        chk("abort_bytes", mon_n - s_n, 0);
        chk("abort_verdicts", (mon_ok - s_ok) + (mon_bad - s_bad), 0);
        chk("abort_cnt", {cnt_ok, cnt_bad}, {exp_cnt_ok[15:0], exp_cnt_bad[15:0]});

        // reset at payload byte 20, remainder dropped, then back-to-back good frames
        build_frame(60, -1);
        send_frame(-1, 1'b0, 19, 2);
        @(negedge rxclk); #1;
        chk("rstf_bytes_after", mon_n - s_n, 0);
        chk("rstf_verdicts", (mon_ok - s_ok) + (mon_bad - s_bad), 0);
        snap();
        send_frame(-1, 1'b0, -1, 1);
        send_frame(-1, 1'b0, -1, 3);
        exp_cnt_ok += 2;
        @(negedge rxclk); #1;
        chk("b2b_bytes", mon_n - s_n, 128);
        chk("b2b_ok", mon_ok - s_ok, 2);
        chk("b2b_bad", mon_bad - s_bad, 0);
        chk("b2b_sof_eof", (mon_sof - s_sof) * 16 + (mon_eof - s_eof), 34);
        chk("b2b_cnt", {cnt_ok, cnt_bad}, {exp_cnt_ok[15:0], exp_cnt_bad[15:0]});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
